// File: rtl/cla_word_sequencer_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead word sequencer.
// Holds the FSM state type, the slice width and the default slice count.
package cla_word_sequencer_pkg;

  localparam int SLICE_W         = 4;
  localparam int DEFAULT_NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_word_sequencer_cla_adder.sv
// Purely combinational 4-bit carry-lookahead slice.
// Every carry is expanded from generate/propagate terms, so no carry ripples through the slice.
module cla_adder
  import cla_word_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];

endmodule

// File: rtl/cla_word_sequencer.sv
// Word adder/subtractor that pushes one nibble per cycle through a single shared CLA slice,
// with a valid/ready request side and a valid/ready result side.
module cla_word_sequencer
  import cla_word_sequencer_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES,
  parameter int W       = SLICE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int               CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic               r_carry;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_busy;

  logic [SLICE_W-1:0] w_a_nib [NIBBLES];
  logic [SLICE_W-1:0] w_b_nib [NIBBLES];
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_a_nib[gi] = r_op_a[gi*SLICE_W +: SLICE_W];
      assign w_b_nib[gi] = r_op_b[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  cla_adder u_slice (
    .a   (w_a_nib[r_cnt]),
    .b   (w_b_nib[r_cnt]),
    .cin (r_carry),
    .sum (w_slice_sum),
    .cout(w_slice_cout)
  );

  // Gated with rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n & (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so the caller's cin is dropped.
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == CNT_W'(i)) r_sum[i*SLICE_W +: SLICE_W] <= w_slice_sum;
          end
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_cout      <= w_slice_cout;
            r_ovf       <= (r_op_a[W-1] == r_op_b[W-1]) &&
                           (w_slice_sum[SLICE_W-1] != r_op_a[W-1]);
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_word_sequencer.md
CLA_WORD_SEQUENCER -- requirements
Module: cla_word_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand word.
REQ-002 The block SHALL have parameter W, default 4*NIBBLES (16), meaning the operand and result width, not overridden independently.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning that the request operands are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning that the block can accept a request.
REQ-007 The block SHALL have port a, input, W bits, meaning operand A.
REQ-008 The block SHALL have port b, input, W bits, meaning operand B.
REQ-009 The block SHALL have port sub, input, 1 bit, meaning subtract: 1 computes A-B, 0 computes A+B+cin.
REQ-010 The block SHALL have port cin, input, 1 bit, meaning the carry-in, which is ignored when sub=1.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning that the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning that the consumer accepts the result.
REQ-013 The block SHALL have port sum, output, W bits, meaning the result word.
REQ-014 The block SHALL have port cout, output, 1 bit, meaning the carry out of the MSB slice (for sub=1, 1 means no borrow).
REQ-015 The block SHALL have port ovf, output, 1 bit, meaning two's-complement signed overflow.
REQ-016 The block SHALL have port busy, output, 1 bit, meaning that the block is in state RUN.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN and DONE, and a nibble counter cnt of width clog2(NIBBLES).
REQ-018 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 On accept, the block SHALL latch opA=a, opB=(sub ? ~b : b) and carry=(sub ? 1 : cin), clear cnt, and go to RUN.
REQ-020 In RUN, each cycle SHALL apply nibble cnt of opA and opB, with carry, to one 4-bit CLA slice, write the slice sum into sum[4*cnt+3:4*cnt], register the slice carry-out into carry, and increment cnt.
REQ-021 When cnt=NIBBLES-1 in RUN, the next state SHALL be DONE, with cout set to the final slice carry-out and ovf set to (opA[W-1]==opB[W-1]) && (result[W-1]!=opA[W-1]).
REQ-022 In DONE, out_valid SHALL be 1; sum, cout and ovf SHALL hold stable until out_ready=1, then the block SHALL return to IDLE.
REQ-023 Latency SHALL be exactly NIBBLES+1 rising edges from the accept edge to out_valid=1 (5 edges at default); the minimum request spacing SHALL be NIBBLES+2 cycles.
REQ-024 in_valid, a, b, sub and cin SHALL be ignored outside IDLE; a request held through RUN/DONE is accepted only on the next IDLE cycle.
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 Wrap-around: a result exceeding W bits SHALL truncate to W bits, with the carry reported only on cout.
REQ-027 After the return to IDLE, sum, cout and ovf SHALL retain their last values and out_valid SHALL be 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0 and busy=0.
REQ-029 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after deassertion.
REQ-030 Reset asserted in RUN or DONE SHALL discard the operation in progress, and no out_valid pulse SHALL follow.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the slice width constant (4) and the default NIBBLES.
REQ-032 The block SHALL contain exactly one instance of the team's existing 4-bit carry-lookahead slice cla_adder, reused every RUN cycle; no other arithmetic on the sum path is permitted.
REQ-033 All state, operand, carry and result registers SHALL reside in cla_word_sequencer; the slice SHALL remain purely combinational.

Verification
REQ-034 Bench SHALL cover: a=0x1234, b=0x1111, sub=0, cin=0 -> sum=0x2345, cout=0, ovf=0, out_valid rising 5 edges after accept.
REQ-035 Bench SHALL cover: a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0 (full ripple across all slices).
REQ-036 Bench SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; and a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0.
REQ-037 Bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid, sum, cout and ovf stable and in_ready=0 throughout; out_ready=1 -> IDLE the next cycle.
REQ-038 Bench SHALL cover: rst_n pulsed low at RUN cycle 2 -> outputs zero immediately, no out_valid, and a new request with a=0x0F0F, b=0x00F1 -> sum=0x1000.
REQ-039 Bench SHALL cover: 1000 random back-to-back requests with random out_ready -> every result matches the reference model {cout,sum}=a±b(+cin).
